// File: rtl/pinky_fetch.sv
// Instruction fetch unit: a credit-gated imem request stream feeding a DEPTH-entry queue toward decode.
// Optional prefix folding (PRE words merged into the next immediate) compiled in with PINKY_PREFOLD_EN.
module pinky_fetch #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        jump,
  input  logic [15:0] target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_ir,
  output logic [15:0] out_pc,
  output logic [15:0] out_im
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [15:0] ir;
    logic [15:0] pc;
    logic [15:0] im;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          head, new_e;
  logic [15:0]     fpc_q, fpc_d, ipc_q, ipc_d;
  logic [CW-1:0]   cnt_q, cnt_d, level;
  logic [AW-1:0]   rp_q, rp_d, wp_q, wp_d;
  logic            infl_q, infl_d;
  logic            enq, deq, word_enq;
  logic [15:0]     word_im;

  // Counting the in-flight word as occupied guarantees room for every return.
  assign level     = cnt_q + CW'(infl_q);
  assign imem_req  = reset & ~jump & (level < CW'(DEPTH));
  assign imem_addr = fpc_q;

  assign out_valid = reset & (cnt_q != '0);
  assign deq       = out_valid & out_ready;
  assign head      = mem_q[rp_q];
  assign out_ir    = out_valid ? head.ir : '0;
  assign out_pc    = out_valid ? head.pc : '0;
  assign out_im    = out_valid ? head.im : '0;

`ifdef PINKY_PREFOLD_EN
  logic        havepre_q, havepre_d, is_pre, fold;
  logic [11:0] pre_q, pre_d;

  assign is_pre   = (imem_data[13:12] == 2'b00);
  assign fold     = havepre_q & ~is_pre & imem_data[8] & (imem_data[14:9] <= 6'h1a);
  assign word_enq = ~is_pre;
  assign word_im  = fold ? {pre_q, imem_data[3:0]} : {{12{imem_data[3]}}, imem_data[3:0]};

  always_comb begin
    havepre_d = havepre_q;
    pre_d     = pre_q;
    if (jump) begin
      havepre_d = 1'b0;
    end else if (infl_q) begin
      if (is_pre) begin
        havepre_d = 1'b1;
        pre_d     = imem_data[11:0];
      end else if (fold) begin
        havepre_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      havepre_q <= 1'b0;
      pre_q     <= '0;
    end else begin
      havepre_q <= havepre_d;
      pre_q     <= pre_d;
    end
  end
`else
  assign word_enq = 1'b1;
  assign word_im  = {{12{imem_data[3]}}, imem_data[3:0]};
`endif

  assign enq   = reset & infl_q & ~jump & word_enq;
  assign new_e = '{ir: imem_data, pc: ipc_q, im: word_im};

  always_comb begin
    fpc_d  = fpc_q;
    ipc_d  = ipc_q;
    cnt_d  = cnt_q;
    rp_d   = rp_q;
    wp_d   = wp_q;
    infl_d = 1'b0;
    if (jump) begin
      // Redirect wins over any dequeue in the same cycle; the consumer squashes it.
      fpc_d = target;
      cnt_d = '0;
      rp_d  = '0;
      wp_d  = '0;
    end else begin
      if (imem_req) begin
        fpc_d = fpc_q + 16'd1;
        ipc_d = fpc_q;
      end
      infl_d = imem_req;
      if (enq) wp_d = wp_q + AW'(1);
      if (deq) rp_d = rp_q + AW'(1);
      cnt_d = cnt_q + CW'(enq) - CW'(deq);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fpc_q  <= '0;
      ipc_q  <= '0;
      cnt_q  <= '0;
      rp_q   <= '0;
      wp_q   <= '0;
      infl_q <= 1'b0;
    end else begin
      fpc_q  <= fpc_d;
      ipc_q  <= ipc_d;
      cnt_q  <= cnt_d;
      rp_q   <= rp_d;
      wp_q   <= wp_d;
      infl_q <= infl_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem_q[wp_q] <= new_e;
  end
endmodule

// File: tb/tb_pinky_fetch.sv
// Random and directed bench for pinky_fetch against a queue-based reference of the fetch rules.
// Prefix-folding expectations follow PINKY_PREFOLD_EN as well.
module tb_pinky_fetch;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_data = '0;
  logic        jump = 1'b0;
  logic [15:0] target = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_ir, out_pc, out_im;

  pinky_fetch #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_data(imem_data), .jump(jump), .target(target), .out_valid(out_valid),
    .out_ready(out_ready), .out_ir(out_ir), .out_pc(out_pc), .out_im(out_im)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ir;
    logic [15:0] pc;
    logic [15:0] im;
  } ent_t;

  logic [15:0] mem [0:65535];
  ent_t        q [$];
  logic [15:0] m_fpc = '0, m_ipc = '0;
  logic        m_infl = 1'b0;
  logic        hp = 1'b0;
  logic [11:0] pre = '0;
  int          total = 0, bad = 0;
  logic        last_v, last_req;
  logic [15:0] last_pc, last_im, last_ir, last_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] sext4(input logic [15:0] w);
    return {{12{w[3]}}, w[3:0]};
  endfunction

  // Apply one returned word to the reference queue.
  task automatic absorb(input logic [15:0] w, input logic [15:0] pc);
    ent_t e;
    e.ir = w; e.pc = pc; e.im = sext4(w);
`ifdef PINKY_PREFOLD_EN
    if (w[13:12] == 2'b00) begin
      hp = 1'b1; pre = w[11:0];
      return;
    end
    if (hp && w[8] && w[14:9] <= 6'h1a) begin
      e.im = {pre, w[3:0]}; hp = 1'b0;
    end
`endif
    q.push_back(e);
  endtask

  task automatic step(input logic r, input logic j, input logic [15:0] t, input logic rdy);
    logic exp_req, exp_v;
    @(negedge clk);
    reset = r; jump = j; target = t; out_ready = rdy;
    #1;
    exp_req = r && !j && (q.size() + int'(m_infl) < DEPTH);
    exp_v   = r && q.size() != 0;
    chk("imem_req", imem_req, exp_req);
    if (exp_req) chk("imem_addr", imem_addr, m_fpc);
    chk("out_valid", out_valid, exp_v);
    if (exp_v) begin
      chk("out_ir", out_ir, q[0].ir);
      chk("out_pc", out_pc, q[0].pc);
      chk("out_im", out_im, q[0].im);
    end
    if (!r) begin
      chk("rst_ir", out_ir, 16'h0);
      chk("rst_pc", out_pc, 16'h0);
      chk("rst_im", out_im, 16'h0);
    end
    last_v = out_valid; last_req = imem_req; last_addr = imem_addr;
    last_pc = out_pc; last_im = out_im; last_ir = out_ir;
    @(posedge clk);
    if (!r) begin
      q.delete(); m_infl = 1'b0; m_fpc = '0; hp = 1'b0;
    end else begin
      if (exp_v && rdy) void'(q.pop_front());
      if (j) begin
        q.delete(); m_infl = 1'b0; m_fpc = t; hp = 1'b0;
      end else begin
        if (m_infl) absorb(mem[m_ipc], m_ipc);
        m_infl = exp_req;
        if (exp_req) begin
          m_ipc = m_fpc; m_fpc = m_fpc + 16'd1;
        end
      end
    end
    #1;
    imem_data = last_req ? mem[last_addr] : 16'($urandom);
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
    for (int a = 0; a < 6; a++) mem[a] = 16'h1101 + 16'(a);
    for (int a = 0; a < 8; a++) mem[16'h40 + a] = 16'h1000 | 16'(a);
    mem[16'h80] = 16'h0ABC;
    mem[16'h81] = 16'h1105;
    mem[16'h82] = 16'h1106;

    // Reset state
    for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("rst_valid", last_v, 1'b0);
    chk("rst_req", last_req, 1'b0);

    // Streaming
    for (int c = 0; c < 8; c++) begin
      step(1'b1, 1'b0, 16'h0, 1'b1);
      if (c >= 2) begin
        chk("stream_v", last_v, 1'b1);
        chk("stream_pc", last_pc, 16'(c - 2));
      end else begin
        chk("stream_v", last_v, 1'b0);
      end
    end

    // Backpressure
    for (int c = 0; c < 2; c++) step(1'b0, 1'b0, 16'h0, 1'b0);
    for (int c = 0; c < 10; c++) step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("bp_req", last_req, 1'b0);
    chk("bp_v", last_v, 1'b1);
    chk("bp_pc", last_pc, 16'h0);
    for (int c = 0; c < 8; c++) begin
      step(1'b1, 1'b0, 16'h0, 1'b1);
      if (c < 6) chk("bp_drain_pc", last_pc, 16'(c));
    end

    // Redirect with 3 queued and 1 in flight
    for (int c = 0; c < 2; c++) step(1'b0, 1'b0, 16'h0, 1'b0);
    for (int c = 0; c < 4; c++) step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b1, 16'h0040, 1'b1);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("jmp_v", last_v, 1'b0);
    chk("jmp_req", last_req, 1'b1);
    chk("jmp_addr", last_addr, 16'h0040);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("jmp_head_v", last_v, 1'b1);
    chk("jmp_head_pc", last_pc, 16'h0040);

    // Prefix folding stream
    step(1'b1, 1'b1, 16'h0080, 1'b0);
    for (int c = 0; c < 5; c++) step(1'b1, 1'b0, 16'h0, 1'b0);
`ifdef PINKY_PREFOLD_EN
    chk("fold_pc", last_pc, 16'h0081);
    chk("fold_im", last_im, 16'hABC5);
`else
    chk("nofold_pc", last_pc, 16'h0080);
    chk("nofold_im", last_im, 16'hFFFC);
`endif
    step(1'b1, 1'b0, 16'h0, 1'b1);
    step(1'b1, 1'b0, 16'h0, 1'b0);
`ifdef PINKY_PREFOLD_EN
    chk("fold_next_pc", last_pc, 16'h0082);
    chk("fold_next_im", last_im, 16'h0006);
`else
    chk("nofold_next_pc", last_pc, 16'h0081);
    chk("nofold_next_im", last_im, 16'h0005);
`endif

    // Reset one cycle after a request
    step(1'b1, 1'b0, 16'h0, 1'b1);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("mid_rst_v", last_v, 1'b0);
    chk("mid_rst_ir", last_ir, 16'h0);
    step(1'b1, 1'b0, 16'h0, 1'b1);
    chk("mid_rst_req", last_req, 1'b1);
    chk("mid_rst_addr", last_addr, 16'h0);

    // Fetch pointer wrap
    step(1'b1, 1'b1, 16'hFFFE, 1'b1);
    for (int c = 0; c < 8; c++) step(1'b1, 1'b0, 16'h0, 1'($urandom_range(0, 1)));

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 99) != 0,
           $urandom_range(0, 15) == 0,
           ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 300)),
           $urandom_range(0, 2) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
